// File: rtl/ibex_fp_pkg.sv
// ============================================================================
// Module : ibex_fp_pkg
// Brief  : Shared FP register-file types and constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ibex_fp_pkg;

  localparam int unsigned FP_NUM_REGS = 32;
  localparam int unsigned FP_FLEN_MAX = 64;

  localparam logic [31:0] FP_NANBOX_HI = 32'hFFFF_FFFF;

  typedef logic [4:0] fp_addr_t;

  typedef struct packed {
    logic                   we;
    fp_addr_t               addr;
    logic [FP_FLEN_MAX-1:0] data;
    logic                   single;
  } fp_wb_t;

endpackage

`default_nettype wire

// File: rtl/ibex_fp_scoreboard.sv
// ============================================================================
// Module : ibex_fp_scoreboard
// Brief  : Busy bits for FP destinations of in-flight ops (flush > set > clear).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ibex_fp_scoreboard
  import ibex_fp_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   set,
  input  fp_addr_t               set_addr,
  input  logic [FP_NUM_REGS-1:0] clr_vec,
  input  logic                   flush,
  output logic [FP_NUM_REGS-1:0] busy_o
);

  logic [FP_NUM_REGS-1:0] r_busy;
  logic [FP_NUM_REGS-1:0] w_busy_nxt;

  // A set wins over a same-cycle write-back so a WAW reissue stays tracked.
  always_comb begin
    w_busy_nxt = r_busy & ~clr_vec;
    if (set) begin
      w_busy_nxt[set_addr] = 1'b1;
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_o = r_busy;

endmodule

`default_nettype wire

// File: rtl/ibex_fp_regfile_sb.sv
// ============================================================================
// Module : ibex_fp_regfile_sb
// Brief  : Flip-flop FP register file with write bypass, NaN-boxing and scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ibex_fp_regfile_sb
  import ibex_fp_pkg::*;
#(
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          NumReadPorts  = 3,
  parameter int unsigned          NumWritePorts = 2,
  parameter bit                   WriteBypass   = 1'b1,
  parameter bit                   NanBox        = 1'b1,
  parameter logic [DataWidth-1:0] ResetVal      = '0
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  fp_addr_t [NumReadPorts-1:0]              raddr_i,
  output logic [NumReadPorts-1:0][DataWidth-1:0]   rdata_o,
  output logic [NumReadPorts-1:0]                  rbusy_o,
  input  logic                                     sb_set_i,
  input  fp_addr_t                                 sb_set_addr_i,
  input  logic                                     flush_i,
  input  logic [NumWritePorts-1:0]                 we_i,
  input  fp_addr_t [NumWritePorts-1:0]             waddr_i,
  input  logic [NumWritePorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumWritePorts-1:0]                 wsingle_i,
  output logic [FP_NUM_REGS-1:0]                   busy_o,
  output logic                                     err_o
);

  logic [DataWidth-1:0]                   r_regs [FP_NUM_REGS];
  logic                                   r_err;
  logic [NumWritePorts-1:0][DataWidth-1:0] w_wdata;
  logic [FP_NUM_REGS-1:0]                 w_clr_vec;
  logic [FP_NUM_REGS-1:0]                 w_busy;
  logic                                   w_conflict;

  for (genvar j = 0; j < NumWritePorts; j++) begin : g_wr
    if (NanBox && DataWidth == 64) begin : g_nanbox
      assign w_wdata[j] = wsingle_i[j] ? {FP_NANBOX_HI, wdata_i[j][31:0]} : wdata_i[j];
    end else begin : g_plain
      logic w_unused_single;
      assign w_unused_single = wsingle_i[j];
      assign w_wdata[j]      = wdata_i[j];
    end
  end

  // Ports are applied in ascending order so the highest index wins a collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < FP_NUM_REGS; r++) begin
        r_regs[r] <= ResetVal;
      end
    end else begin
      for (int j = 0; j < NumWritePorts; j++) begin
        if (we_i[j]) begin
          r_regs[waddr_i[j]] <= w_wdata[j];
        end
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NumWritePorts; i++) begin
      for (int j = i + 1; j < NumWritePorts; j++) begin
        if (we_i[i] && we_i[j] && (waddr_i[i] == waddr_i[j])) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_conflict;
    end
  end

  assign err_o = r_err;

  always_comb begin
    w_clr_vec = '0;
    for (int j = 0; j < NumWritePorts; j++) begin
      if (we_i[j]) begin
        w_clr_vec[waddr_i[j]] = 1'b1;
      end
    end
  end

  ibex_fp_scoreboard u_scoreboard (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .set      (sb_set_i),
    .set_addr (sb_set_addr_i),
    .clr_vec  (w_clr_vec),
    .flush    (flush_i),
    .busy_o   (w_busy)
  );

  assign busy_o = w_busy;

  for (genvar k = 0; k < NumReadPorts; k++) begin : g_rd
    logic [DataWidth-1:0] w_data;
    logic                 w_hit;

    always_comb begin
      w_data = r_regs[raddr_i[k]];
      w_hit  = 1'b0;
      if (WriteBypass) begin
        for (int j = 0; j < NumWritePorts; j++) begin
          if (we_i[j] && (waddr_i[j] == raddr_i[k])) begin
            w_data = w_wdata[j];
            w_hit  = 1'b1;
          end
        end
      end
    end

    // A result arriving this cycle already satisfies the hazard.
    assign rdata_o[k] = w_data;
    assign rbusy_o[k] = w_busy[raddr_i[k]] & ~w_hit;
  end

  a_data_width : assert property (@(posedge clk_i) (DataWidth == 32) || (DataWidth == 64));
  a_num_wports : assert property (@(posedge clk_i) NumWritePorts >= 1);
  a_we_known   : assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(we_i));

endmodule

`default_nettype wire

// File: tb/tb_ibex_fp_regfile_sb.sv
// ============================================================================
// Module : tb_ibex_fp_regfile_sb
// Brief  : Directed scoreboard bench for ibex_fp_regfile_sb (FLEN=64, 3R/2W).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ibex_fp_regfile_sb;
  import ibex_fp_pkg::*;

  localparam int DW = 64;
  localparam int NR = 3;
  localparam int NW = 2;

  localparam int K_RDATA = 0;
  localparam int K_RBUSY = 1;
  localparam int K_BUSY  = 2;
  localparam int K_ERR   = 3;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  fp_addr_t [NR-1:0]         raddr_i;
  logic [NR-1:0][DW-1:0]     rdata_o;
  logic [NR-1:0]             rbusy_o;
  logic                      sb_set_i;
  fp_addr_t                  sb_set_addr_i;
  logic                      flush_i;
  logic [NW-1:0]             we_i;
  fp_addr_t [NW-1:0]         waddr_i;
  logic [NW-1:0][DW-1:0]     wdata_i;
  logic [NW-1:0]             wsingle_i;
  logic [31:0]               busy_o;
  logic                      err_o;

  ibex_fp_regfile_sb #(
    .DataWidth     (DW),
    .NumReadPorts  (NR),
    .NumWritePorts (NW),
    .WriteBypass   (1'b1),
    .NanBox        (1'b1),
    .ResetVal      ('0)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .raddr_i       (raddr_i),
    .rdata_o       (rdata_o),
    .rbusy_o       (rbusy_o),
    .sb_set_i      (sb_set_i),
    .sb_set_addr_i (sb_set_addr_i),
    .flush_i       (flush_i),
    .we_i          (we_i),
    .waddr_i       (waddr_i),
    .wdata_i       (wdata_i),
    .wsingle_i     (wsingle_i),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_val(input string n, input int kind, input int port, input logic [63:0] e);
    exp_t x;
    x.name = n;
    x.kind = kind;
    x.port = port;
    x.exp  = e;
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    we_i      = '0;
    wsingle_i = '0;
    sb_set_i  = 1'b0;
    flush_i   = 1'b0;
  endtask

  // Checks every queued expectation against the outputs settled mid-cycle.
  always @(negedge clk_i) begin : monitor
    exp_t        x;
    logic [63:0] act;
    while (q.size() > 0) begin
      x = q.pop_front();
      case (x.kind)
        K_RDATA: act = rdata_o[x.port];
        K_RBUSY: act = {63'd0, rbusy_o[x.port]};
        K_BUSY:  act = {32'd0, busy_o};
        default: act = {63'd0, err_o};
      endcase
      total++;
      if (act !== x.exp) begin
        bad++;
        $display("FAIL %s: actual=%h required=%h", x.name, act, x.exp);
      end
    end
  end

  initial begin
    raddr_i       = '0;
    waddr_i       = '0;
    wdata_i       = '0;
    sb_set_addr_i = '0;
    idle();
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    expect_val("reset_busy", K_BUSY, 0, 64'd0);
    expect_val("reset_err", K_ERR, 0, 64'd0);
    for (int r = 0; r < 32; r++) begin
      if (r > 0) cyc();
      for (int k = 0; k < NR; k++) begin
        raddr_i[k] = fp_addr_t'(r);
        expect_val("reset_rdata", K_RDATA, k, 64'd0);
        expect_val("reset_rbusy", K_RBUSY, k, 64'd0);
      end
    end

    // f0 is an ordinary register
    cyc();
    we_i[0] = 1'b1; waddr_i[0] = 5'd0; wdata_i[0] = 64'h3F80_0000;
    cyc();
    idle();
    raddr_i[0] = 5'd0;
    expect_val("f0_write", K_RDATA, 0, 64'h3F80_0000);
    expect_val("nonbusy_write_busy", K_BUSY, 0, 64'd0);

    // NaN-boxed single write, bypassed then registered
    cyc();
    we_i[0] = 1'b1; waddr_i[0] = 5'd5; wdata_i[0] = 64'h0000_0000_4049_0FDB; wsingle_i[0] = 1'b1;
    raddr_i[1] = 5'd5;
    expect_val("nanbox_bypass", K_RDATA, 1, 64'hFFFF_FFFF_4049_0FDB);
    cyc();
    idle();
    raddr_i[2] = 5'd5;
    expect_val("nanbox_reg", K_RDATA, 2, 64'hFFFF_FFFF_4049_0FDB);

    // Two ports to f7: port 1 wins, err pulses
    cyc();
    we_i = 2'b11; waddr_i[0] = 5'd7; waddr_i[1] = 5'd7;
    wdata_i[0] = 64'h1; wdata_i[1] = 64'h2;
    raddr_i[0] = 5'd7;
    expect_val("conflict_bypass", K_RDATA, 0, 64'h2);
    expect_val("conflict_err_pre", K_ERR, 0, 64'd0);
    cyc();
    idle();
    expect_val("conflict_data", K_RDATA, 0, 64'h2);
    expect_val("conflict_err", K_ERR, 0, 64'd1);
    cyc();
    expect_val("conflict_err_clr", K_ERR, 0, 64'd0);

    // Scoreboard set, then write-back with bypass
    cyc();
    sb_set_i = 1'b1; sb_set_addr_i = 5'd9;
    cyc();
    idle();
    raddr_i[0] = 5'd9; raddr_i[1] = 5'd9;
    expect_val("sb9_busy", K_BUSY, 0, 64'h200);
    expect_val("sb9_rbusy0", K_RBUSY, 0, 64'd1);
    expect_val("sb9_rbusy1", K_RBUSY, 1, 64'd1);
    cyc();
    we_i[1] = 1'b1; waddr_i[1] = 5'd9; wdata_i[1] = 64'h1234_5678_9ABC_DEF0;
    expect_val("wb9_rdata", K_RDATA, 0, 64'h1234_5678_9ABC_DEF0);
    expect_val("wb9_rbusy", K_RBUSY, 0, 64'd0);
    expect_val("wb9_busy_hold", K_BUSY, 0, 64'h200);
    cyc();
    idle();
    expect_val("wb9_busy_clr", K_BUSY, 0, 64'd0);
    expect_val("wb9_reg", K_RDATA, 1, 64'h1234_5678_9ABC_DEF0);

    // Set beats same-cycle clear; flush beats set and does not block writes
    cyc();
    sb_set_i = 1'b1; sb_set_addr_i = 5'd3;
    we_i[0] = 1'b1; waddr_i[0] = 5'd3; wdata_i[0] = 64'hA5;
    cyc();
    idle();
    raddr_i[0] = 5'd3;
    expect_val("set_beats_clr", K_BUSY, 0, 64'h8);
    expect_val("set_beats_clr_rbusy", K_RBUSY, 0, 64'd1);
    expect_val("f3_data", K_RDATA, 0, 64'hA5);
    cyc();
    flush_i = 1'b1; sb_set_i = 1'b1; sb_set_addr_i = 5'd4;
    we_i[1] = 1'b1; waddr_i[1] = 5'd20; wdata_i[1] = 64'h5A;
    cyc();
    idle();
    raddr_i[1] = 5'd20; raddr_i[2] = 5'd4;
    expect_val("flush_busy", K_BUSY, 0, 64'd0);
    expect_val("flush_write", K_RDATA, 1, 64'h5A);
    expect_val("flush_rbusy4", K_RBUSY, 2, 64'd0);

    // Asynchronous reset while an op is in flight
    cyc();
    sb_set_i = 1'b1; sb_set_addr_i = 5'd12;
    cyc();
    idle();
    expect_val("sb12_busy", K_BUSY, 0, 64'h1000);
    cyc();
    #1;
    rst_ni = 1'b0;
    raddr_i[0] = 5'd20;
    expect_val("async_rst_busy", K_BUSY, 0, 64'd0);
    expect_val("async_rst_data", K_RDATA, 0, 64'd0);
    cyc();
    rst_ni = 1'b1;

    @(negedge clk_i);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
